// File: rtl/pe16_slice_unloader_if.sv
// Host-side bundle for pe16_slice_unloader: PE BRAM port A plus the lane-word output stream.
interface pe16_slice_unloader_if #(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int ADDR_W          = 10
);
    // PE BRAM port A
    logic              external;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [15:0]       douta;

    // lane-word stream
    logic                       m_valid;
    logic                       m_ready;
    logic [MAX_WORD_LENGTH-1:0] m_data;
    logic [3:0]                 m_lane;
    logic                       m_last;

    modport master (
        output external, wea, addra, m_valid, m_data, m_lane, m_last,
        input  douta, m_ready
    );

    modport slave (
        input  external, wea, addra, m_valid, m_data, m_lane, m_last,
        output douta, m_ready
    );
endinterface

// File: rtl/pe16_slice_unloader.sv
// Fetches L bit-slice rows from the PE BRAM, transposes them into 16 lane words and streams them out.
// Define SIGNED_UNLOAD_EN to sign-extend bits >= L_eff of each word instead of zero-filling them.

// One lane's word buffer: bit cap_idx is loaded from this lane's douta bit on each captured row.
module pe16_slice_unloader_lane #(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [IW-1:0] cap_idx,
    input  logic          din,
    output logic [W-1:0]  word
);
    always_ff @(posedge clk) begin
        if (reset)       word          <= '0;
        else if (cap_en) word[cap_idx] <= din;
    end
endmodule

module pe16_slice_unloader #(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int ADDR_W          = 10,
    parameter int RD_LAT          = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [5:0]           length,
    output logic                 busy,
    output logic                 done,
    pe16_slice_unloader_if.master bus
);
    localparam int LW = $clog2(MAX_WORD_LENGTH + 1);
    localparam int IW = $clog2(MAX_WORD_LENGTH);
    localparam int NUM_LANES = 16;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [LW-1:0]          len_in, len_q, len_m1;
    logic [LW-1:0]          iss_cnt, cap_cnt;
    logic [RD_LAT:0]        vld_pipe;
    logic [3:0]             lane_q;
    logic                   done_q;
    logic                   accept, issue, cap_en, last_cap, beat, fin;
    logic [NUM_LANES-1:0][MAX_WORD_LENGTH-1:0] lane_word;
    logic [MAX_WORD_LENGTH-1:0] mask, word_out;

    always_comb begin
        len_in = (int'(length) > MAX_WORD_LENGTH) ? LW'(MAX_WORD_LENGTH) : LW'(length);
    end

    assign accept   = (state == IDLE) && start;
    // Row 0 goes out on the accepting edge so the pipeline starts without a bubble.
    assign issue    = (accept && (len_in != '0)) || ((state == FETCH) && (iss_cnt < len_q));
    // vld_pipe[RD_LAT] marks the cycle the issued row is present on douta.
    assign cap_en   = (state == FETCH) && vld_pipe[RD_LAT];
    assign len_m1   = len_q - LW'(1);
    assign last_cap = cap_en && (cap_cnt == len_m1);
    assign beat     = (state == DRAIN) && bus.m_ready;
    assign fin      = beat && (lane_q == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                if (len_q == '0)   state_nxt = IDLE;
                else if (last_cap) state_nxt = DRAIN;
            end
            DRAIN: if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            iss_cnt  <= '0;
            cap_cnt  <= '0;
            vld_pipe <= '0;
            lane_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= ((state == FETCH) && (len_q == '0)) || fin;
            vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
            if (accept) begin
                base_q  <= base_addr;
                len_q   <= len_in;
                cap_cnt <= '0;
                lane_q  <= '0;
                iss_cnt <= (len_in != '0) ? LW'(1) : '0;
                if (len_in != '0) addr_q <= base_addr;
            end else if (state == FETCH) begin
                if (issue) begin
                    addr_q  <= base_q + ADDR_W'(iss_cnt);
                    iss_cnt <= iss_cnt + LW'(1);
                end
                if (cap_en) cap_cnt <= cap_cnt + LW'(1);
            end else if (beat) begin
                lane_q <= lane_q + 4'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pe16_slice_unloader_lane #(.W(MAX_WORD_LENGTH), .IW(IW)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .cap_en  (cap_en),
            .cap_idx (cap_cnt[IW-1:0]),
            .din     (bus.douta[g]),
            .word    (lane_word[g])
        );
    end

    // Buffer bits above L_eff may hold rows from an earlier, longer unload; mask them off.
    always_comb begin
        mask = '0;
        for (int b = 0; b < MAX_WORD_LENGTH; b++) mask[b] = (b < int'(len_q));
        word_out = lane_word[lane_q] & mask;
`ifdef SIGNED_UNLOAD_EN
        if ((len_q != '0) && lane_word[lane_q][IW'(len_m1)]) word_out = word_out | ~mask;
`endif
    end

    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign bus.external = busy;
    assign bus.wea      = 1'b0;
    assign bus.addra    = addr_q;
    assign bus.m_valid  = (state == DRAIN);
    assign bus.m_lane   = lane_q;
    assign bus.m_last   = (state == DRAIN) && (lane_q == 4'd15);
    assign bus.m_data   = word_out;
endmodule

// File: tb/tb_pe16_slice_unloader.sv
// Self-checking bench for pe16_slice_unloader: BRAM model, randomized sink, word-level reference model.
module tb_pe16_slice_unloader;
    localparam int MAXW   = 32;
    localparam int AW     = 10;
    localparam int RD_LAT = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [5:0]    length;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [1024];
    logic [15:0] rd_pipe [RD_LAT];
    logic [31:0] got [16];

    pe16_slice_unloader_if #(.MAX_WORD_LENGTH(MAXW), .ADDR_W(AW)) bus ();

    pe16_slice_unloader #(.MAX_WORD_LENGTH(MAXW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM read port with RD_LAT cycles from address to data
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.addra];
        for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign bus.douta = rd_pipe[RD_LAT-1];

    // Lane word straight from the definition: bit k is lane bit of row base+k.
    function automatic logic [31:0] ref_word(int lane, int b, int len);
        int l;
        logic [31:0] w;
        l = (len > MAXW) ? MAXW : len;
        w = '0;
        for (int k = 0; k < l; k++) w[k] = mem[(b + k) % 1024][lane];
`ifdef SIGNED_UNLOAD_EN
        if (l > 0 && w[l-1]) for (int k = l; k < 32; k++) w[k] = 1'b1;
`endif
        return w;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 1024; r++) mem[r] = 16'($urandom);
    endtask

    // One full unload with a sink ready rdy_pct percent of the time; records words in got[].
    task automatic unload(input int b, input int len, input int rdy_pct);
        int l, lat, n, idx;
        logic [31:0] exp_w [16];
        logic        stalled;
        logic [31:0] pd;
        logic [3:0]  pl;
        logic [AW-1:0] ea;
        l   = (len > MAXW) ? MAXW : len;
        lat = l + RD_LAT;
        for (int i = 0; i < 16; i++) exp_w[i] = ref_word(i, b, len);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); length = 6'(len); bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0; idx = 0; stalled = 1'b0; pd = '0; pl = '0;
        while (n < 400) begin
            if (n < lat) begin
                n_checks++;
                if ({busy, bus.external, bus.m_valid, done} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL fetch_status n=%0d: busy/ext/valid/done got %b want 1100", n, {busy, bus.external, bus.m_valid, done});
                end
                if (n < l) begin
                    ea = AW'(b + n);
                    n_checks++;
                    if (bus.addra !== ea || bus.wea !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fetch_addr k=%0d: addra got %0d want %0d wea %b", n, bus.addra, ea, bus.wea);
                    end
                end
            end else if (idx < 16) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_lane !== 4'(idx) || bus.m_data !== exp_w[idx] ||
                    bus.m_last !== (idx == 15) || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_word lane=%0d: valid %b lane %0d data %h last %b done %b want data %h",
                             idx, bus.m_valid, bus.m_lane, bus.m_data, bus.m_last, done, exp_w[idx]);
                end
                if (stalled) begin
                    n_checks++;
                    if (bus.m_data !== pd || bus.m_lane !== pl) begin
                        n_fail++;
                        $display("FAIL stall_hold: data %h lane %0d want %h lane %0d", bus.m_data, bus.m_lane, pd, pl);
                    end
                end
                got[idx]    = bus.m_data;
                pd          = bus.m_data;
                pl          = bus.m_lane;
                bus.m_ready = ($urandom_range(99) < rdy_pct);
                stalled     = !bus.m_ready;
                if (bus.m_ready) idx++;
            end else begin
                bus.m_ready = 1'b0;
                n_checks++;
                if ({busy, bus.external, bus.m_valid, bus.m_last, done} !== 5'b00001) begin
                    n_fail++;
                    $display("FAIL done_pulse: busy/ext/valid/last/done got %b want 00001", {busy, bus.external, bus.m_valid, bus.m_last, done});
                end
                break;
            end
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL unload_timeout: lanes accepted %0d want 16", idx);
        end
        @(negedge clk);
        ea = AW'(b + l - 1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.addra !== ea) begin
            n_fail++;
            $display("FAIL post_done: done %b busy %b addra %0d want 0 0 %0d", done, busy, bus.addra, ea);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, bus.external, bus.m_valid, bus.m_last, bus.wea} !== 6'b0 ||
            bus.addra !== '0 || bus.m_data !== '0 || bus.m_lane !== '0) begin
            n_fail++;
            $display("FAIL reset_state: flags %b addra %0d data %h lane %0d want all 0",
                     {busy, done, bus.external, bus.m_valid, bus.m_last, bus.wea}, bus.addra, bus.m_data, bus.m_lane);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0]  v;
        logic [31:0] e;
        fill_random();
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 16; i++) begin
                v = 8'(i * 17);
                mem[k][i] = v[k];
            end
        unload(0, 8, 100);
        for (int i = 0; i < 16; i++) begin
            v = 8'(i * 17);
`ifdef SIGNED_UNLOAD_EN
            e = {{24{v[7]}}, v};
`else
            e = {24'h0, v};
`endif
            n_checks++;
            if (got[i] !== e) begin
                n_fail++;
                $display("FAIL basic_lane%0d: got %h want %h", i, got[i], e);
            end
        end
    endtask

    task automatic test_wrap();
        fill_random();
        unload(1022, 4, 100);
    endtask

    task automatic test_stall();
        for (int t = 0; t < 3; t++) begin
            fill_random();
            unload($urandom_range(1023), $urandom_range(1, 32), 50);
        end
    endtask

    task automatic test_len0();
        @(negedge clk);
        start = 1'b1; base_addr = 10'd77; length = 6'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, bus.m_valid, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL len0_cycle1: busy/valid/done got %b want 100", {busy, bus.m_valid, done});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, bus.m_valid, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL len0_done: busy/valid/done got %b want 001", {busy, bus.m_valid, done});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, bus.m_valid, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL len0_after: busy/valid/done got %b want 000", {busy, bus.m_valid, done});
        end
    endtask

    task automatic test_clamp();
        fill_random();
        unload(100, 40, 100);
    endtask

    task automatic test_sign();
        logic [3:0]  pat;
        logic [31:0] e;
        pat = 4'b1010;
        fill_random();
        for (int k = 0; k < 4; k++) mem[200 + k][3] = pat[k];
        unload(200, 4, 70);
`ifdef SIGNED_UNLOAD_EN
        e = 32'hFFFF_FFFA;
`else
        e = 32'h0000_000A;
`endif
        n_checks++;
        if (got[3] !== e) begin
            n_fail++;
            $display("FAIL sign_lane3: got %h want %h", got[3], e);
        end
    endtask

    task automatic abort_check(input string tag);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, bus.external, bus.m_valid, bus.m_last, done} !== 5'b0 || bus.addra !== '0 || bus.m_data !== '0) begin
            n_fail++;
            $display("FAIL %s: flags %b addra %0d data %h want all 0", tag,
                     {busy, bus.external, bus.m_valid, bus.m_last, done}, bus.addra, bus.m_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_nodone: done %b busy %b want 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        fill_random();
        @(negedge clk);
        start = 1'b1; base_addr = 10'd5; length = 6'd20; bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort_check("abort_fetch");
        @(negedge clk);
        start = 1'b1; base_addr = 10'd9; length = 6'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (bus.m_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_reach: m_valid %b want 1", bus.m_valid);
        end
        @(negedge clk);
        abort_check("abort_drain");
        unload(7, 12, 100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_clamp();
        test_sign();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
